// File: rtl/nor_operand_loader.sv
// Operand front-end for nor_4bits: loads A then B from the switches on debounced
// load presses, then captures the NOR result with a valid flag.
module nor_operand_loader #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_load,
    input  logic             btn_clear,
    input  logic [WIDTH-1:0] Y_in,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic [1:0]       state_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        EVAL   = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t        state;
    logic          ld_meta, ld_sync, ld_stable, ld_stable_q;
    logic          clr_meta, clr_sync;
    logic [CW-1:0] ld_cnt;
    logic          load_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_meta  <= 1'b0;
            ld_sync  <= 1'b0;
            clr_meta <= 1'b0;
            clr_sync <= 1'b0;
        end else begin
            ld_meta  <= btn_load;
            ld_sync  <= ld_meta;
            clr_meta <= btn_clear;
            clr_sync <= clr_meta;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES unequal samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt      <= '0;
            ld_stable   <= 1'b0;
            ld_stable_q <= 1'b0;
        end else begin
            ld_stable_q <= ld_stable;
            if (ld_sync == ld_stable) begin
                ld_cnt <= '0;
            end else if (ld_cnt == CNT_LAST) begin
                ld_stable <= ld_sync;
                ld_cnt    <= '0;
            end else if (ld_cnt != '1) begin
                ld_cnt <= ld_cnt + CNT_ONE;
            end
        end
    end

    assign load_pulse = ld_stable & ~ld_stable_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A      <= '0;
            B      <= '0;
            result <= '0;
            valid  <= 1'b0;
            state  <= LOAD_A;
        end else if (clr_sync) begin
            A      <= '0;
            B      <= '0;
            result <= '0;
            valid  <= 1'b0;
            state  <= LOAD_A;
        end else begin
            unique case (state)
                LOAD_A: if (load_pulse) begin
                    A     <= sw;
                    state <= LOAD_B;
                end
                LOAD_B: if (load_pulse) begin
                    B     <= sw;
                    state <= EVAL;
                end
                EVAL: begin
                    result <= Y_in;
                    valid  <= 1'b1;
                    state  <= DONE;
                end
                DONE: if (load_pulse) begin
                    A     <= sw;
                    valid <= 1'b0;
                    state <= LOAD_B;
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_nor_operand_loader.sv
// Directed and randomized checks of nor_operand_loader against an operation-level
// model of the load/evaluate/clear sequence; nor_4bits is modelled inline.
module tb_nor_operand_loader;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw = '0;
    logic         btn_load = 1'b0;
    logic         btn_clear = 1'b0;
    logic [W-1:0] y_in;
    logic [W-1:0] a_o, b_o, result_o;
    logic         valid_o;
    logic [1:0]   state_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: operand registers plus "which operand comes next".
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic         m_valid = 1'b0;
    logic [1:0]   m_st = 2'b00;

    always #5 clk = ~clk;

    always_comb y_in = ~(a_o | b_o);

    nor_operand_loader #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_load (btn_load),
        .btn_clear(btn_clear),
        .Y_in     (y_in),
        .A        (a_o),
        .B        (b_o),
        .result   (result_o),
        .valid    (valid_o),
        .state_o  (state_o)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".A"},      {4'b0, a_o},      {4'b0, m_a});
        check({tag, ".B"},      {4'b0, b_o},      {4'b0, m_b});
        check({tag, ".result"}, {4'b0, result_o}, {4'b0, m_res});
        check({tag, ".valid"},  {7'b0, valid_o},  {7'b0, m_valid});
        check({tag, ".state"},  {6'b0, state_o},  {6'b0, m_st});
        if (valid_o)
            check({tag, ".nor"}, {4'b0, result_o}, {4'b0, ~(a_o | b_o)});
    endtask

    task automatic model_clear();
        m_a = '0; m_b = '0; m_res = '0; m_valid = 1'b0; m_st = 2'b00;
    endtask

    // Press with exact latency check: 2 sync + 4 debounce edges, load on the 7th.
    task automatic press(input logic [W-1:0] v, input string tag);
        @(negedge clk);
        sw = v;
        btn_load = 1'b1;
        repeat (6) @(posedge clk);
        #1 check_all({tag, ".pre"});
        @(posedge clk);
        #1;
        if (m_st == 2'b01) begin
            m_b = v;
            m_st = 2'b10;
            check_all({tag, ".loadB"});
            @(posedge clk);
            #1;
            m_res = ~(m_a | m_b);
            m_valid = 1'b1;
            m_st = 2'b11;
            check_all({tag, ".eval"});
        end else begin
            m_a = v;
            m_valid = 1'b0;
            m_st = 2'b01;
            check_all({tag, ".loadA"});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        btn_load = 1'b0;
        repeat (12) @(posedge clk);
        #1 check_all({tag, ".rel"});
    endtask

    task automatic clear_seq(input string tag);
        @(negedge clk);
        btn_clear = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_all({tag, ".preclr"});
        @(posedge clk);
        #1;
        model_clear();
        check_all({tag, ".clr"});
        @(negedge clk);
        btn_clear = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_all({tag, ".postclr"});
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1 check_all("por");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_all("por_rel");

        // Full load sequence: 0101, 0011 -> 1000
        press(4'b0101, "full_a");
        press(4'b0011, "full_b");
        check("full_res", {4'b0, result_o}, 8'h08);

        // Clear in DONE together with a load press; clear wins and the load is lost
        @(negedge clk);
        sw = 4'b1110;
        btn_clear = 1'b1;
        btn_load = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_all("clr_pre");
        @(posedge clk);
        #1;
        model_clear();
        check_all("clr_now");
        repeat (10) @(posedge clk);
        #1 check_all("clr_held");
        @(negedge clk);
        btn_clear = 1'b0;
        repeat (8) @(posedge clk);
        #1 check_all("clr_rel");
        @(negedge clk);
        btn_load = 1'b0;
        repeat (12) @(posedge clk);
        #1 check_all("clr_ldrel");

        // Bounce rejection in LOAD_A
        sw = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            btn_load = 1'b1;
            repeat (2) @(negedge clk);
            btn_load = 1'b0;
            repeat (3) @(negedge clk);
            #1 check_all("bounce");
        end
        repeat (8) @(posedge clk);
        press(4'b1001, "bounce_hold");
        press(4'b0110, "bounce_b");

        // Operand sweep
        press(4'b0000, "sw0a"); press(4'b0000, "sw0b");
        check("sweep0", {4'b0, result_o}, 8'h0f);
        press(4'b0001, "sw1a"); press(4'b0010, "sw1b");
        check("sweep1", {4'b0, result_o}, 8'h0c);
        press(4'b1111, "sw2a"); press(4'b1111, "sw2b");
        check("sweep2", {4'b0, result_o}, 8'h00);
        press(4'b1010, "sw3a"); press(4'b0101, "sw3b");
        check("sweep3", {4'b0, result_o}, 8'h00);

        // Reload from DONE keeps B until overwritten
        press(4'b0101, "rl_a"); press(4'b0011, "rl_b");
        press(4'b1111, "rl_a2");
        check("rl_keepB", {4'b0, b_o}, 8'h03);
        check("rl_inval", {7'b0, valid_o}, 8'h00);
        press(4'b0000, "rl_b2");
        check("rl_res", {4'b0, result_o}, 8'h00);
        check("rl_valid", {7'b0, valid_o}, 8'h01);

        // Asynchronous reset mid-LOAD_B with A=0101
        press(4'b0101, "rst_setup");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_all("rst_async");
        repeat (2) @(posedge clk);
        #1 check_all("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_all("rst_rel");

        // Randomized presses with occasional clears
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0)
                clear_seq("rnd_clr");
            else
                press(W'($urandom), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nor_operand_loader.md
Name: nor_operand_loader

Overview:
- Front-end stage directly upstream of the nor_4bits datapath in the lab's bitwise-logic unit.
- Captures operand A, then operand B, from the 4-bit board switches on debounced presses of a load pushbutton.
- Drives the registered operands into nor_4bits and registers its combinational result Y into a held result with a valid flag for the LEDs.
- Sequenced by a 4-state FSM; one clock domain.

Parameters:
WIDTH, 4, operand/result width in bits (matches nor_4bits)
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a button level change is accepted (>=2; board build uses 250000)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
sw  input  WIDTH  board switches (quasi-static, sampled on load)
btn_load  input  1  raw active-high load pushbutton (asynchronous, bouncy)
btn_clear  input  1  raw active-high clear pushbutton (asynchronous)
Y_in  input  WIDTH  result from nor_4bits (combinational function of A, B)
A  output  WIDTH  registered operand A to nor_4bits
B  output  WIDTH  registered operand B to nor_4bits
result  output  WIDTH  captured NOR result
valid  output  1  result holds the NOR of the current A and B
state_o  output  2  FSM state for debug LEDs: 00 LOAD_A, 01 LOAD_B, 10 EVAL, 11 DONE

Behaviour:
- Reset (rst_n low, asynchronous, any cycle): A=0, B=0, result=0, valid=0, state=LOAD_A, synchronizers, debounce counter and stable level all cleared. Operation resumes on the first clk edge after rst_n is released.
- btn_load path:
  - 2-FF synchronizer feeds ld_sync.
  - Counter increments while ld_sync != ld_stable and resets to 0 whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still unequal, ld_stable <= ld_sync and the counter clears.
  - ld_stable_q is ld_stable delayed one cycle. load_pulse = ld_stable & ~ld_stable_q, high exactly 1 cycle per accepted press.
  - A release never pulses. Any glitch shorter than DEBOUNCE_CYCLES synchronized samples is ignored.
- btn_clear path: 2-FF synchronizer only, giving clr_sync as a level. Clear has priority over load_pulse in the same cycle.
- FSM transitions (all synchronous):
  - LOAD_A: on load_pulse, A<=sw, go to LOAD_B.
  - LOAD_B: on load_pulse, B<=sw, go to EVAL.
  - EVAL (exactly 1 cycle, unconditional): result<=Y_in, valid<=1, go to DONE. Y_in already reflects the new B because A and B are registered one edge earlier.
  - DONE: hold all outputs. On load_pulse, A<=sw, valid<=0, go to LOAD_B. B and result keep their old values until overwritten.
  - Any state with clr_sync=1: A=0, B=0, result=0, valid=0, state=LOAD_A. Clear is held for as long as clr_sync stays high.
- load_pulse during EVAL is dropped; no queuing. A pulse only occurs on a new press, so a held button loads once.
- Latency:
  - Raw press to A/B update: 2 synchronizer edges + DEBOUNCE_CYCLES edges + 1 edge.
  - B load to valid=1: 1 clk edge.
- Widths: all operand/result paths are WIDTH bits, no extension or truncation. The debounce counter is $clog2(DEBOUNCE_CYCLES)+1 bits and saturates rather than wraps.
- valid=1 implies result == ~(A|B) at all times outside reset.

Test Plan:
- (1) Reset, DEBOUNCE_CYCLES=4:
  - Stimulus: rst_n low mid-LOAD_B with A=0101; release.
  - Required: A=0000, B=0000, result=0000, valid=0, state_o=00 immediately on assertion, held through release.
- (2) Full load sequence:
  - Stimulus: sw=0101, press btn_load for 10 cycles; sw=0011, press again.
  - Required: A=0101, B=0011, state_o passes through 10 for exactly 1 cycle, then result=1000, valid=1, state_o=11.
- (3) Operand sweep:
  - Pairs (0000,0000), (0001,0010), (1111,1111), (1010,0101).
  - Required results: 1111, 1100, 0000, 0000, each with valid=1 one edge after B loads.
- (4) Bounce rejection:
  - Stimulus: in LOAD_A, toggle btn_load with high pulses of 2 cycles separated by low gaps, then hold high 10 cycles.
  - Required: exactly one A load, no change to A before the stable hold, state_o=01.
- (5) Clear:
  - Stimulus: in DONE with result=1000, assert btn_clear together with a load press.
  - Required: after 2 synchronizer edges plus 1 edge, all outputs are 0 and state_o=00; the load is ignored.
- (6) Reload from DONE:
  - Stimulus: sw=1111, press.
  - Required: A=1111, valid=0, B unchanged (0011), state_o=01. Then sw=0000, press: result=0000, valid=1.
